// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle sequencer for the RV32M MUL/DIV/REM group. It runs next to the
//   single-cycle ALU and handles one radix-2 iteration per clock: shift-add for
//   multiplies and restoring division for divides/remainders. Divide-by-zero
//   and signed overflow skip the iterations and finish one cycle after start.
//
// Ports
//   clk     in   1           clock, all state on rising edge
//   reset   in   1           asynchronous active-high reset
//   start   in   1           request, sampled only while idle
//   Funct3  in   3           000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                            100 DIV,101 DIVU,110 REM,111 REMU
//   SrcA    in   DATA_WIDTH  rs1 (dividend / multiplicand)
//   SrcB    in   DATA_WIDTH  rs2 (divisor / multiplier)
//   busy    out  1           iterating
//   stall   out  1           pipeline hold (combinational)
//   done    out  1           one-cycle pulse, Result valid
//   Result  out  DATA_WIDTH  last finished result
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   MIN_W    = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    hi_q, hi_d;      // partial product high half / partial remainder
  logic [W-1:0]    lo_q, lo_d;      // multiplier-side low half / dividend-quotient
  logic [W-1:0]    opb_q, opb_d;    // magnitude added (multiply) or subtracted (divide)
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;    // final result needs two's-complement negation
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    result_q, result_d;

  logic            a_signed_s, b_signed_s, sa_s, sb_s;
  logic [W-1:0]    mag_a_s, mag_b_s;
  logic            div_zero_s, ovf_s;
  logic [W-1:0]    special_res_s;
  logic [W:0]      mul_sum_s, div_shift_s, div_diff_s;
  logic [W-1:0]    step_hi_s, step_lo_s;
  logic [2*W-1:0]  fin_raw_s, fin_s;
  logic [W-1:0]    fin_sel_s;

  // Operand decode at the start request: signedness, magnitudes, special cases
  always_comb begin
    a_signed_s = (Funct3 == 3'b001) | (Funct3 == 3'b010) |
                 (Funct3 == 3'b100) | (Funct3 == 3'b110);
    b_signed_s = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
    sa_s       = a_signed_s & SrcA[W-1];
    sb_s       = b_signed_s & SrcB[W-1];
    mag_a_s    = sa_s ? (~SrcA + ONE_W) : SrcA;
    mag_b_s    = sb_s ? (~SrcB + ONE_W) : SrcB;
    div_zero_s = (SrcB == {W{1'b0}});
    // Signed overflow only exists for DIV/REM (Funct3[0] clear)
    ovf_s      = ~Funct3[0] & (SrcA == MIN_W) & (SrcB == {W{1'b1}});
    if (div_zero_s) begin
      special_res_s = Funct3[1] ? SrcA : {W{1'b1}};
    end else begin
      special_res_s = Funct3[1] ? {W{1'b0}} : SrcA;
    end
  end

  // One radix-2 iteration plus sign correction of the value it produces
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    div_shift_s = {hi_q, lo_q[W-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    step_hi_s   = hi_q;
    step_lo_s   = lo_q;
    case (state_q)
      S_MUL_RUN: begin
        step_hi_s = mul_sum_s[W:1];
        step_lo_s = {mul_sum_s[0], lo_q[W-1:1]};
      end
      S_DIV_RUN: begin
        // Restoring step: keep the difference only when it did not go negative
        if (!div_diff_s[W]) begin
          step_hi_s = div_diff_s[W-1:0];
          step_lo_s = {lo_q[W-2:0], 1'b1};
        end else begin
          step_hi_s = div_shift_s[W-1:0];
          step_lo_s = {lo_q[W-2:0], 1'b0};
        end
      end
      default: begin
        step_hi_s = hi_q;
        step_lo_s = lo_q;
      end
    endcase

    if (state_q == S_MUL_RUN) begin
      fin_raw_s = {step_hi_s, step_lo_s};
    end else if (f3_q[1]) begin
      fin_raw_s = {{W{1'b0}}, step_hi_s};
    end else begin
      fin_raw_s = {{W{1'b0}}, step_lo_s};
    end
    // The low W bits of a 2W negation equal the W-bit negation, so one negator serves both
    fin_s = neg_q ? (~fin_raw_s + ONE_2W) : fin_raw_s;
    if ((state_q == S_MUL_RUN) && (f3_q[1:0] != 2'b00)) begin
      fin_sel_s = fin_s[2*W-1:W];
    end else begin
      fin_sel_s = fin_s[W-1:0];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = Funct3;
          cnt_d = {CW{1'b0}};
          hi_d  = {W{1'b0}};
          lo_d  = mag_a_s;
          opb_d = mag_b_s;
          if (!Funct3[2]) begin
            state_d = S_MUL_RUN;
            neg_d   = sa_s ^ sb_s;
            busy_d  = 1'b1;
          end else if (div_zero_s | ovf_s) begin
            state_d  = S_FINISH;
            neg_d    = 1'b0;
            result_d = special_res_s;
            done_d   = 1'b1;
          end else begin
            state_d = S_DIV_RUN;
            // Remainder takes the dividend's sign, quotient the XOR of both
            neg_d   = Funct3[1] ? sa_s : (sa_s ^ sb_s);
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        hi_d = step_hi_s;
        lo_d = step_lo_s;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_FINISH;
          cnt_d    = {CW{1'b0}};
          result_d = fin_sel_s;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      S_FINISH: begin
        // A start seen here is ignored; decode re-asserts it in the next idle cycle
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      f3_q     <= 3'b000;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;
  // Hold decode the same cycle it asks, and for every iteration cycle
  assign stall  = ((state_q == S_IDLE) & start) | busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = 32'h0;
  logic [31:0] SrcB = 32'h0;
  logic        busy, stall, done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .stall(stall),
    .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M-extension semantics via wide integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    int              ia = a;
    int              ib = b;
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Issue one op (start for one cycle), count edges to done, check result/latency/stall
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k = 0;
    bit seen = 0;
    bit stall_ok = 1;
    @(negedge clk);
    start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    while (!seen && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
      if (done) begin
        seen = 1;
        if (stall) stall_ok = 0;
      end else if (!stall || !busy) begin
        stall_ok = 0;
      end
    end
    check({name, " latency"}, 32'(k), 32'(exp_lat));
    check({name, " result"}, Result, exp);
    check({name, " stall"}, {31'd0, stall_ok}, 32'd1);
    @(negedge clk);
    check({name, " done pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int k;
    bit seen, stall_ok;

    vecs[0]  = '{"MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{"MULH 7*-3",       3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vecs[2]  = '{"MULHU max*max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{"MULHSU -1*2",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{"DIV -7/2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{"REM -7/2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{"DIVU 100/7",      3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{"REMU 100/7",      3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{"DIV 5/0",         3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"REMU 5/0",        3'd7, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{"DIV ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"REM ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    vecs[12] = '{"DIVU 5/0",        3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{"REM 5/0",         3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[14] = '{"DIVU min/max",    3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
    vecs[15] = '{"REMU min/max",    3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};

    // Reset state
    #12;
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset done",   {31'd0, done},  32'd0);
    check("reset stall",  {31'd0, stall}, 32'd0);
    check("reset Result", Result,         32'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Randomized ops against the reference model, with special cases mixed in
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("random", f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
    end

    // Reset in the middle of a divide (count 10)
    @(negedge clk);
    start = 1'b1; Funct3 = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst busy",   {31'd0, busy}, 32'd0);
    check("midrst Result", Result,        32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("midrst no done", {31'd0, seen}, 32'd0);
    check("midrst Result held", Result, 32'd0);
    run_op("after reset DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // start held high, operands changing mid-op
    @(negedge clk);
    start = 1'b1; Funct3 = 3'd0; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
    k = 0; seen = 0; stall_ok = 1;
    while (!seen && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      SrcA = $urandom; SrcB = $urandom;
      if (done) seen = 1;
      else if (!stall) stall_ok = 0;
    end
    check("held latency", 32'(k), 32'd33);
    check("held result", Result, 32'hFFFF_FFEB);
    check("held stall run", {31'd0, stall_ok}, 32'd1);
    check("held stall finish", {31'd0, stall}, 32'd0);
    Funct3 = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk);
    @(negedge clk);
    check("held idle busy", {31'd0, busy}, 32'd0);
    check("held idle stall", {31'd0, stall}, 32'd1);
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      SrcA = $urandom;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("held next latency", 32'(k), 32'd33);
    check("held next result", Result, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
